sub_bytes_pipe: RTL and testbench

SUB_BYTES_PIPE -- requirements
Module: sub_bytes_pipe

---
 rtl/aes_sbox_pkg.sv | 44 ++++
 rtl/sbox_lane.sv | 12 +
 rtl/sub_bytes_pipe.sv | 85 ++++++++
 tb/tb_sub_bytes_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_pkg.sv
// Byte type and the FIPS-197 AES forward and inverse substitution tables.
package aes_sbox_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam byte_t SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of AES SubBytes / InvSubBytes, purely combinational.
module sbox_lane
   import aes_sbox_pkg::*;
(
   input  byte_t data,
   input  logic  inv,
   output byte_t result
);

   assign result = inv ? SBOX_INV[data] : SBOX_FWD[data];

endmodule

// File: rtl/sub_bytes_pipe.sv
// Two-stage valid/ready pipeline applying a per-beat forward or inverse AES S-box to every byte lane.
module sub_bytes_pipe
   import aes_sbox_pkg::*;
#(
   parameter int LANES = 4,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic               in_inv,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic [1:0]         occupancy
);

   logic               vld_p1, vld_p2;
   logic               adv_p1, adv_p2;
   logic               nxt_vld_p1, nxt_vld_p2;
   logic [8*LANES-1:0] data_p1, sub_p1, data_p2;
   logic               inv_p1;
   logic [TAG_W-1:0]   tag_p1, tag_p2;
   logic [1:0]         occ;

   assign adv_p2     = !vld_p2 || out_ready;
   assign adv_p1     = !vld_p1 || adv_p2;
   assign nxt_vld_p1 = adv_p1 ? in_valid : vld_p1;
   assign nxt_vld_p2 = adv_p2 ? vld_p1 : vld_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         occ    <= 2'd0;
      end else begin
         vld_p1 <= nxt_vld_p1;
         vld_p2 <= nxt_vld_p2;
         occ    <= {1'b0, nxt_vld_p1} + {1'b0, nxt_vld_p2};
      end
   end

   // Stage 1: capture the raw input beat (only real beats, so idle cycles leave payload untouched)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p1 <= '0;
         inv_p1  <= 1'b0;
         tag_p1  <= '0;
      end else if (adv_p1 && in_valid) begin
         data_p1 <= in_data;
         inv_p1  <= in_inv;
         tag_p1  <= in_tag;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sbox_lane u_lane (
         .data   (data_p1[8*i +: 8]),
         .inv    (inv_p1),
         .result (sub_p1[8*i +: 8])
      );
   end

   // Stage 2: capture the substituted bytes and the tag that travelled with them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p2 <= '0;
         tag_p2  <= '0;
      end else if (adv_p2 && vld_p1) begin
         data_p2 <= sub_p1;
         tag_p2  <= tag_p1;
      end
   end

   assign in_ready  = adv_p1;
   assign out_valid = vld_p2;
   assign out_data  = data_p2;
   assign out_tag   = tag_p2;
   assign occupancy = occ;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench driving LANES=1, 4 and 16 instances in lockstep against a GF(2^8)-derived S-box scoreboard.
module tb_sub_bytes_pipe;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_inv = 1'b0;
   logic [3:0]   in_tag = '0;
   logic         out_ready = 1'b0;

   logic         in_ready_1, in_ready_4, in_ready_16;
   logic         out_valid_1, out_valid_4, out_valid_16;
   logic [7:0]   out_data_1;
   logic [31:0]  out_data_4;
   logic [127:0] out_data_16;
   logic [3:0]   out_tag_1, out_tag_4, out_tag_16;
   logic [1:0]   occ_1, occ_4, occ_16;

   always #5 clk = ~clk;

   sub_bytes_pipe #(.LANES(1), .TAG_W(4)) dut_1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
      .in_data(in_data[7:0]), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(out_valid_1), .out_ready(out_ready), .out_data(out_data_1),
      .out_tag(out_tag_1), .occupancy(occ_1));

   sub_bytes_pipe #(.LANES(4), .TAG_W(4)) dut_4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
      .in_data(in_data[31:0]), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(out_valid_4), .out_ready(out_ready), .out_data(out_data_4),
      .out_tag(out_tag_4), .occupancy(occ_4));

   sub_bytes_pipe #(.LANES(16), .TAG_W(4)) dut_16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_16),
      .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(out_valid_16), .out_ready(out_ready), .out_data(out_data_16),
      .out_tag(out_tag_16), .occupancy(occ_16));

   typedef struct {
      logic [127:0] data;
      logic [3:0]   tag;
      int           acc;
   } beat_t;

   beat_t        sb[$];
   logic [7:0]   fwd_tab [256];
   logic [7:0]   inv_tab [256];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           emitted = 0;
   bit           acc_last = 1'b0;
   bit           hold_prev = 1'b0;
   logic [127:0] hold_data;
   logic [3:0]   hold_tag;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
         fwd_tab[x] = s;
         inv_tab[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
      return r;
   endfunction

   // One clock: check state at the falling edge, update the scoreboard, advance past the rising edge
   task automatic tick();
      int cnt;
      bit exp_ov;
      @(negedge clk);
      cnt    = sb.size();
      exp_ov = (cnt > 0) && (cyc >= sb[0].acc + 1);
      chk("occ4", occ_4, cnt);
      chk("occ1", occ_1, cnt);
      chk("occ16", occ_16, cnt);
      chk("in_ready4", in_ready_4, (cnt < 2) || out_ready);
      chk("in_ready1", in_ready_1, (cnt < 2) || out_ready);
      chk("in_ready16", in_ready_16, (cnt < 2) || out_ready);
      chk("out_valid4", out_valid_4, exp_ov);
      chk("out_valid1", out_valid_1, exp_ov);
      chk("out_valid16", out_valid_16, exp_ov);
      if (hold_prev) begin
         chk("hold_valid", out_valid_16, 1'b1);
         chk("hold_data", out_data_16, hold_data);
         chk("hold_tag", out_tag_16, hold_tag);
      end
      if (out_valid_4 && out_ready) begin
         if (sb.size() == 0) chk("underflow", out_valid_4, 1'b0);
         else begin
            beat_t b = sb.pop_front();
            chk("data16", out_data_16, b.data);
            chk("data4", out_data_4, b.data[31:0]);
            chk("data1", out_data_1, b.data[7:0]);
            chk("tag4", out_tag_4, b.tag);
            chk("tag1", out_tag_1, b.tag);
            chk("tag16", out_tag_16, b.tag);
            emitted++;
         end
      end
      acc_last = in_valid && in_ready_4;
      if (acc_last) sb.push_back('{data: ref_sub(in_data, in_inv), tag: in_tag, acc: cyc + 1});
      hold_prev = out_valid_16 && !out_ready;
      hold_data = out_data_16;
      hold_tag  = out_tag_16;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic new_beat(input bit inv);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_inv  = inv;
      in_tag  = 4'($urandom);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      int e0;
      int beats;
      build_tables();

      // reset state
      #12;
      chk("rst_occ", occ_4, 2'd0);
      chk("rst_valid", out_valid_4, 1'b0);
      chk("rst_ready", in_ready_4, 1'b1);
      chk("rst_data", out_data_16, 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_rst_data", out_data_4, 32'h0);
      chk("post_rst_tag", out_tag_4, 4'h0);

      // forward known vector
      in_data = {$urandom, $urandom, $urandom, 32'hFF530100};
      in_inv = 1'b0; in_tag = 4'h3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("fwd_valid", out_valid_4, 1'b1);
      chk("fwd_data", out_data_4, 32'h16ED7C63);
      chk("fwd_tag", out_tag_4, 4'h3);
      tick();

      // inverse round-trip vector
      in_data = {$urandom, $urandom, $urandom, 32'h16ED7C63};
      in_inv = 1'b1; in_tag = 4'hA; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("inv_data", out_data_4, 32'hFF530100);
      chk("inv_tag", out_tag_4, 4'hA);
      drain();

      // back-to-back beats with alternating mode
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         new_beat(i[0]);
         tick();
      end
      drain();

      // backpressure: three beats with the output stalled
      e0 = emitted;
      out_ready = 1'b0;
      in_valid = 1'b1;
      new_beat(1'b0); tick();
      new_beat(1'b1); tick();
      new_beat(1'b0);
      chk("bp_occ", occ_4, 2'd2);
      chk("bp_ready", in_ready_4, 1'b0);
      tick(); tick();
      chk("bp_stall", sb.size(), 2);
      out_ready = 1'b1;
      for (int i = 0; i < 5 && in_valid; i++) begin
         tick();
         if (acc_last) in_valid = 1'b0;
      end
      drain();
      chk("bp_count", emitted - e0, 3);

      // sustained throughput
      e0 = emitted;
      beats = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 102; i++) begin
         in_valid = (beats < 100);
         if (in_valid) new_beat(1'($urandom));
         tick();
         if (acc_last) beats++;
      end
      chk("thru_in", beats, 100);
      chk("thru_out", emitted - e0, 100);
      in_valid = 1'b0;

      // reset while full
      out_ready = 1'b0;
      in_valid = 1'b1;
      new_beat(1'b0); tick();
      new_beat(1'b1); tick();
      chk("mid_occ_full", occ_4, 2'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_valid", out_valid_4, 1'b0);
      chk("mid_occ", occ_4, 2'd0);
      chk("mid_valid16", out_valid_16, 1'b0);
      sb.delete();
      hold_prev = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // random valid and ready toggling
      acc_last = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (!in_valid || acc_last) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            new_beat(1'($urandom));
         end
         out_ready = 1'($urandom_range(0, 2) != 0);
         tick();
      end
      drain();
      chk("final_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
